// File: rtl/alu_accumulator.sv
// Sums TAPS accepted ALU results per window and delivers the sum over a valid/ready handshake.
// Define ALU_ACCUMULATOR_SAT_EN to saturate the accumulator on carry instead of wrapping.
module alu_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int TAPS   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rdy_en_q;
    logic               accept;
    logic [ACC_W:0]     sum;

    // Returns {carry, next accumulator}; saturating build clamps the low bits on carry.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(b);
`ifdef ALU_ACCUMULATOR_SAT_EN
        if (s[ACC_W]) begin
            s[ACC_W-1:0] = '1;
        end
`endif
        return s;
    endfunction

    assign in_ready  = rdy_en_q && (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign sum       = acc_add(acc_q, in_data);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (acc_clr) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = ACC_W'(in_data);
                        ovf_d   = 1'b0;
                        cnt_d   = CNT_W'(1);
                        state_d = (TAPS == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d = sum[ACC_W-1:0];
                        ovf_d = ovf_q | sum[ACC_W];
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(TAPS - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // rdy_en_q keeps in_ready low while reset is asserted and until the first free-running edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_accumulator.sv
// Scoreboard bench: a 16-bit and a 10-bit accumulator share one stimulus stream.
module tb_alu_accumulator;

    localparam int TAPS = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        acc_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b0;

    logic        in_ready16, out_valid16, out_ovf16, busy16;
    logic [15:0] out_sum16;
    logic        in_ready10, out_valid10, out_ovf10, busy10;
    logic [9:0]  out_sum10;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // Reference model state
    logic        m_rdy  = 1'b0;
    logic        m_hold = 1'b0;
    int          m_cnt  = 0;
    int unsigned m_raw  = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    alu_accumulator #(.DATA_W(8), .ACC_W(16), .TAPS(TAPS)) dut16 (
        .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready16), .out_valid(out_valid16), .out_ready(out_ready),
        .out_sum(out_sum16), .out_ovf(out_ovf16), .busy(busy16));

    alu_accumulator #(.DATA_W(8), .ACC_W(10), .TAPS(TAPS)) dut10 (
        .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready10), .out_valid(out_valid10), .out_ready(out_ready),
        .out_sum(out_sum10), .out_ovf(out_ovf10), .busy(busy10));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned exp_sum(input int unsigned raw, input int w);
        int unsigned lim;
        lim = 32'd1 << w;
        if (raw < lim) return raw;
`ifdef ALU_ACCUMULATOR_SAT_EN
        return lim - 1;
`else
        return raw % lim;
`endif
    endfunction

    function automatic logic exp_ovf(input int unsigned raw, input int w);
        return raw >= (32'd1 << w);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rdy = 1'b0; m_hold = 1'b0; m_cnt = 0; m_raw = 0;
            exp_q.delete();
        end else begin
            if (acc_clr) begin
                m_hold = 1'b0; m_cnt = 0; m_raw = 0;
                exp_q.delete();
            end else if (m_hold) begin
                if (out_ready) m_hold = 1'b0;
            end else if (m_rdy && in_valid) begin
                m_raw = m_raw + in_data;
                m_cnt++;
                if (m_cnt == TAPS) begin
                    exp_q.push_back(m_raw);
                    m_raw = 0; m_cnt = 0; m_hold = 1'b1;
                end
            end
            m_rdy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int unsigned raw;
            check("in_ready16", in_ready16, m_rdy && !m_hold);
            check("in_ready10", in_ready10, m_rdy && !m_hold);
            check("out_valid16", out_valid16, m_hold);
            check("out_valid10", out_valid10, m_hold);
            check("busy16", busy16, m_hold || (m_cnt != 0));
            check("busy10", busy10, m_hold || (m_cnt != 0));
            if (m_hold && out_ready && !acc_clr && rst_n) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 0, 1);
                end else begin
                    raw = exp_q.pop_front();
                    check("sum16", out_sum16, exp_sum(raw, 16));
                    check("ovf16", out_ovf16, exp_ovf(raw, 16));
                    check("sum10", out_sum10, exp_sum(raw, 10));
                    check("ovf10", out_ovf10, exp_ovf(raw, 10));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        logic r;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            r = in_ready16;
            tick();
            n++;
        end while (!r && n < 50);
        if (!r) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_vld", out_valid16, 0);
        check("rst_sum", out_sum16, 0);
        check("rst_ovf", out_ovf16, 0);
        check("rst_busy", busy16, 0);
        check("rst_rdy", in_ready16, 0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("rel_rdy", in_ready16, 1);
        tick();

        // Basic sum 1..9 back to back
        out_ready = 1'b1;
        for (int i = 1; i <= TAPS; i++) send(8'(i));
        @(negedge clk);
        check("t1_lat_vld", out_valid16, 1);
        check("t1_sum", out_sum16, 45);
        check("t1_ovf", out_ovf16, 0);
        tick();
        @(negedge clk);
        check("t1_busy", busy16, 0);
        tick();

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < TAPS; i++) send(8'h10);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rdy", in_ready16, 0);
            check("bp_sum", out_sum16, 144);
            check("bp_vld", out_valid16, 1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hs_rdy", in_ready16, 0);
        tick();
        @(negedge clk);
        check("post_hs_vld", out_valid16, 0);
        check("post_hs_rdy", in_ready16, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("next_busy", busy16, 1);
        check("next_sum", out_sum16, 8'h55);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        @(negedge clk);
        check("clr_busy", busy16, 0);
        tick();

        // Gaps with 0xFF; also overflows the 10-bit instance
        for (int i = 0; i < TAPS; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(8'hFF);
        end
        @(negedge clk);
        check("gap_sum16", out_sum16, 2295);
        check("gap_ovf16", out_ovf16, 0);
`ifdef ALU_ACCUMULATOR_SAT_EN
        check("ovf_sum10", out_sum10, 1023);
`else
        check("ovf_sum10", out_sum10, 247);
`endif
        check("ovf_ovf10", out_ovf10, 1);
        tick();
        for (int i = 0; i < TAPS; i++) send(8'h01);
        @(negedge clk);
        check("ones_sum10", out_sum10, 9);
        check("ones_ovf10", out_ovf10, 0);
        tick();

        // Abort mid-window with a simultaneous sample
        for (int i = 0; i < 4; i++) send(8'h20);
        in_valid = 1'b1;
        in_data  = 8'h20;
        acc_clr  = 1'b1;
        tick();
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        @(negedge clk);
        check("abort_busy", busy16, 0);
        check("abort_sum", out_sum16, 0);
        tick();
        for (int i = 0; i < TAPS; i++) send(8'h01);
        @(negedge clk);
        check("abort_next_sum", out_sum16, 9);
        tick();

        // Abort while holding, with out_ready high
        out_ready = 1'b0;
        for (int i = 0; i < TAPS; i++) send(8'h01);
        out_ready = 1'b1;
        acc_clr   = 1'b1;
        tick();
        acc_clr = 1'b0;
        @(negedge clk);
        check("hold_abort_vld", out_valid16, 0);
        check("hold_abort_busy", busy16, 0);
        tick();

        // Reset mid-window
        for (int i = 0; i < 5; i++) send(8'h03);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("mr_sum", out_sum16, 0);
        check("mr_vld", out_valid16, 0);
        check("mr_busy", busy16, 0);
        check("mr_rdy", in_ready16, 0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("mr_rel_rdy", in_ready16, 1);
        tick();
        for (int i = 0; i < TAPS; i++) send(8'h02);
        @(negedge clk);
        check("mr_next_sum", out_sum16, 18);
        tick();
        tick();
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
